// File: rtl/video_pkg.sv
// Shared video pipeline types: RGB888 pixel and 16x16 chunk layouts.
// Row 0 / col 0 / R channel occupy the MSB end of every chunk.
package video_pkg;

  localparam int CHUNK_ROWS = 16;
  localparam int CHUNK_COLS = 16;
  localparam int PIX_W      = 24;

  typedef logic [2:0][7:0] pixel_t;
  typedef logic [CHUNK_COLS-1:0][2:0][7:0] row_t;
  typedef logic [CHUNK_ROWS-1:0][CHUNK_COLS-1:0][2:0][7:0] chunk_input;
  typedef logic [CHUNK_ROWS-1:0][CHUNK_COLS-1:0][2:0][7:0] chunk_output;

  // Per-channel floor average using a 9-bit sum.
  function automatic pixel_t pix_avg(pixel_t a, pixel_t b);
    pixel_t   r;
    logic [8:0] s;
    for (int c = 0; c < 3; c++) begin
      s    = {1'b0, a[c]} + {1'b0, b[c]};
      r[c] = s[8:1];
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_upscaler_if.sv
// Chunk in / upscaled chunk pair out bundle for the 2x upscaler.
// master drives the input chunks, slave is the upscaler.
interface chunk_upscaler_if;
  import video_pkg::*;

  logic        in_valid;
  logic        first_chunk;
  chunk_input  last_chunk;
  chunk_input  current_chunk;
  logic        out_valid;
  chunk_output output_chunk_current;
  chunk_output output_chunk_next;

  modport master (
    output in_valid,
    output first_chunk,
    output last_chunk,
    output current_chunk,
    input  out_valid,
    input  output_chunk_current,
    input  output_chunk_next
  );

  modport slave (
    input  in_valid,
    input  first_chunk,
    input  last_chunk,
    input  current_chunk,
    output out_valid,
    output output_chunk_current,
    output output_chunk_next
  );

endinterface

// File: rtl/chunk_upscaler_row.sv
// One chunk row (+ left neighbour) -> 32 upscaled pixels, combinational.
// CHUNK_UPSCALER_INTERP_EN selects linear 2x; otherwise pixel replication.
module row_upscaler
  import video_pkg::*;
(
  input  row_t   row_i,
  input  pixel_t left_i,
  input  logic   first_i,
  output row_t   cur_o,
  output row_t   nxt_o
);

  pixel_t u [2*CHUNK_COLS];

`ifdef CHUNK_UPSCALER_INTERP_EN
  pixel_t edge_px;

  // Left context: previous chunk's last pixel, or replicate col 0 at line start.
  always_comb begin
    edge_px = first_i ? row_i[CHUNK_COLS-1] : left_i;
  end

  // Odd outputs copy the source pixel, even outputs average with the left one.
  always_comb begin
    for (int i = 0; i < CHUNK_COLS; i++) begin
      u[2*i+1] = row_i[CHUNK_COLS-1-i];
      if (i == 0)
        u[2*i] = pix_avg(edge_px, row_i[CHUNK_COLS-1]);
      else
        u[2*i] = pix_avg(row_i[CHUNK_COLS-i], row_i[CHUNK_COLS-1-i]);
    end
  end
`else
  logic unused_ctx;

  assign unused_ctx = ^{left_i, first_i};

  // Nearest neighbour: each source pixel fills both output slots.
  always_comb begin
    for (int i = 0; i < CHUNK_COLS; i++) begin
      u[2*i]   = row_i[CHUNK_COLS-1-i];
      u[2*i+1] = row_i[CHUNK_COLS-1-i];
    end
  end
`endif

  // Split the 32-wide row into the two 16-wide output rows, col 0 at MSB.
  always_comb begin
    cur_o = '0;
    nxt_o = '0;
    for (int k = 0; k < CHUNK_COLS; k++) begin
      cur_o[CHUNK_COLS-1-k] = u[k];
      nxt_o[CHUNK_COLS-1-k] = u[CHUNK_COLS+k];
    end
  end

endmodule

// File: rtl/chunk_upscaler.sv
// 2x horizontal chunk upscaler: combinational rows into one output register.
// Build option: CHUNK_UPSCALER_INTERP_EN (linear interp; else replication).
module chunk_upscaler
  import video_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  chunk_upscaler_if.slave  bus
);

  chunk_output cur_d;
  chunk_output nxt_d;
  chunk_output cur_q;
  chunk_output nxt_q;
  logic        vld_q;

  for (genvar r = 0; r < CHUNK_ROWS; r++) begin : g_row
    row_upscaler u_row (
      .row_i   (bus.current_chunk[CHUNK_ROWS-1-r]),
      .left_i  (bus.last_chunk[CHUNK_ROWS-1-r][0]),
      .first_i (bus.first_chunk),
      .cur_o   (cur_d[CHUNK_ROWS-1-r]),
      .nxt_o   (nxt_d[CHUNK_ROWS-1-r])
    );
  end

  // Valid follows in_valid; data only loads on valid so idle cycles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      cur_q <= '0;
      nxt_q <= '0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        cur_q <= cur_d;
        nxt_q <= nxt_d;
      end
    end
  end

  assign bus.out_valid            = vld_q;
  assign bus.output_chunk_current = cur_q;
  assign bus.output_chunk_next    = nxt_q;

endmodule

// File: tb/tb_chunk_upscaler.sv
// Randomised self-checking bench for chunk_upscaler.
// Expected chunks come from a pixel-level model of the 2x upscale rule.
module tb_chunk_upscaler;
  import video_pkg::*;

`ifdef CHUNK_UPSCALER_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chunk_upscaler_if bus ();

  chunk_upscaler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pixel_t gp(chunk_input c, int r, int k);
    return c[15-r][15-k];
  endfunction

  function automatic chunk_input sp(chunk_input c, int r, int k,
                                    pixel_t v);
    c[15-r][15-k] = v;
    return c;
  endfunction

  function automatic int fdiff(chunk_output a, chunk_output b);
    for (int i = 0; i < 256; i++)
      if (gp(a, i/16, i%16) !== gp(b, i/16, i%16)) return i;
    return 0;
  endfunction

  function automatic chunk_input rnd_chunk();
    logic [6143:0] f;
    for (int i = 0; i < 192; i++) f[i*32 +: 32] = $urandom;
    return chunk_input'(f);
  endfunction

  function automatic chunk_input fill(pixel_t v);
    chunk_input c;
    for (int i = 0; i < 256; i++) c = sp(c, i/16, i%16, v);
    return c;
  endfunction

  // Build the 32-wide row U from the source row, then split it in two.
  task automatic model(input chunk_input l, input chunk_input cu,
                       input logic f, output chunk_output oc,
                       output chunk_output on);
    pixel_t a, b, v;
    oc = '0;
    on = '0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 32; k++) begin
        b = gp(cu, r, k/2);
        if (k % 2 == 1 || !INTERP) begin
          v = b;
        end else begin
          if (k == 0) a = f ? gp(cu, r, 0) : gp(l, r, 15);
          else a = gp(cu, r, k/2 - 1);
          for (int ch = 0; ch < 3; ch++)
            v[ch] = 8'((int'(a[ch]) + int'(b[ch])) / 2);
        end
        if (k < 16) oc = sp(oc, r, k, v);
        else on = sp(on, r, k-16, v);
      end
    end
  endtask

  task automatic chk_bit(string nm, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", nm, got, exp);
    end
  endtask

  task automatic chk_chunk(string nm, chunk_output got, chunk_output exp);
    int d;
    checks++;
    if (got !== exp) begin
      errors++;
      d = fdiff(got, exp);
      $display("FAIL %s r%0d c%0d got %h exp %h", nm, d/16, d%16,
               gp(got, d/16, d%16), gp(exp, d/16, d%16));
    end
  endtask

  task automatic chk_px(string nm, pixel_t got, pixel_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic apply(logic v, logic f, chunk_input l, chunk_input c);
    @(negedge clk);
    bus.in_valid      = v;
    bus.first_chunk   = f;
    bus.last_chunk    = l;
    bus.current_chunk = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_valid", bus.out_valid, 1'b0);
    chk_chunk("rst_cur", bus.output_chunk_current, '0);
    chk_chunk("rst_nxt", bus.output_chunk_next, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    chk_bit("rel_valid", bus.out_valid, 1'b0);
    chk_chunk("rel_cur", bus.output_chunk_current, '0);
  endtask

  task automatic test_uniform();
    chunk_input  w;
    chunk_output e;
    w = fill(24'hFFFFFF);
    e = w;
    apply(1'b1, 1'b0, w, w);
    chk_bit("uni_valid", bus.out_valid, 1'b1);
    chk_chunk("uni_cur", bus.output_chunk_current, e);
    chk_chunk("uni_nxt", bus.output_chunk_next, e);
    idle();
    chk_bit("hold_valid", bus.out_valid, 1'b0);
    chk_chunk("hold_cur", bus.output_chunk_current, e);
    chk_chunk("hold_nxt", bus.output_chunk_next, e);
  endtask

  task automatic test_edge();
    chunk_input  l, c;
    chunk_output ec, en;
    l = sp(chunk_input'('0), 0, 15, 24'h0000FF);
    c = sp(chunk_input'('0), 0, 0, 24'hFF0000);
    apply(1'b1, 1'b0, l, c);
    chk_px("edge_c0",
           gp(bus.output_chunk_current, 0, 0),
           INTERP ? 24'h7F007F : 24'hFF0000);
    chk_px("edge_c1", gp(bus.output_chunk_current, 0, 1), 24'hFF0000);
    model(l, c, 1'b0, ec, en);
    chk_chunk("edge_cur", bus.output_chunk_current, ec);
    apply(1'b1, 1'b1, l, c);
    chk_px("first_c0", gp(bus.output_chunk_current, 0, 0), 24'hFF0000);
    model(l, c, 1'b1, ec, en);
    chk_chunk("first_cur", bus.output_chunk_current, ec);
    chk_chunk("first_nxt", bus.output_chunk_next, en);
  endtask

  task automatic test_split();
    chunk_input  c;
    chunk_output ec, en;
    c = '0;
    for (int k = 8; k < 16; k++) c = sp(c, 3, k, 24'hFFFFFF);
    apply(1'b1, 1'b0, '0, c);
    chk_px("split_c15", gp(bus.output_chunk_current, 3, 15), 24'h000000);
    chk_px("split_n0", gp(bus.output_chunk_next, 3, 0),
           INTERP ? 24'h7F7F7F : 24'hFFFFFF);
    chk_px("split_n1", gp(bus.output_chunk_next, 3, 1), 24'hFFFFFF);
    chk_px("split_n15", gp(bus.output_chunk_next, 3, 15), 24'hFFFFFF);
    model('0, c, 1'b0, ec, en);
    chk_chunk("split_nxt", bus.output_chunk_next, en);
  endtask

  task automatic test_random();
    chunk_input  l, c;
    chunk_output ec, en, hc, hn;
    logic        v, f;
    hc = bus.output_chunk_current;
    model('0, '0, 1'b0, ec, en);
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 3) != 0);
      f = $urandom_range(0, 1) == 1;
      l = rnd_chunk();
      c = rnd_chunk();
      if (n == 0) begin
        hc = bus.output_chunk_current;
        hn = bus.output_chunk_next;
      end
      if (v) model(l, c, f, hc, hn);
      apply(v, f, l, c);
      chk_bit("rnd_valid", bus.out_valid, v);
      chk_chunk("rnd_cur", bus.output_chunk_current, hc);
      chk_chunk("rnd_nxt", bus.output_chunk_next, hn);
    end
  endtask

  task automatic test_async_reset();
    chunk_input  c;
    chunk_output ec, en;
    c = rnd_chunk();
    apply(1'b1, 1'b0, rnd_chunk(), c);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("arst_valid", bus.out_valid, 1'b0);
    chk_chunk("arst_cur", bus.output_chunk_current, '0);
    chk_chunk("arst_nxt", bus.output_chunk_next, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    idle();
    chk_bit("arst_rel", bus.out_valid, 1'b0);
    apply(1'b1, 1'b1, '0, c);
    model('0, c, 1'b1, ec, en);
    chk_bit("arst_fresh", bus.out_valid, 1'b1);
    chk_chunk("arst_fcur", bus.output_chunk_current, ec);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.first_chunk = 1'b0;
    bus.last_chunk = '0;
    bus.current_chunk = '0;
    test_reset();
    test_uniform();
    test_edge();
    test_split();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
